quant_sched: RTL
================

Name: quant_sched

Overview:
- Time-multiplexes one shared quantizer engine across the 17 quantization jobs of a 16x16 luma macroblock: one DC job and 16 AC 4x4 blocks.
- Replaces the 17 parallel quantizer instances in the macroblock reconstruct path.
- Sits between the forward-transform stage (issues `start`) and the inverse WHT / IDCT stages, which consume per-job write strobes.
- Drives the engine's start and select, waits for its done, and flags hung jobs.

Parameters:
- NUM_AC, 16, number of AC jobs; the DC job index equals NUM_AC.
- TIMEOUT, 64, maximum cycles from `q_start` to `q_done` before a job is declared hung.
- IDX_W, 5, width of the job index; must satisfy 2^IDX_W > NUM_AC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: macroblock transform results valid; begin sequencing
- ac_nz  in  NUM_AC  per-AC-block nonzero-coefficient mask; sampled when `start` is accepted
- busy  out  1  high from the cycle after `start` is accepted until the cycle `done` is asserted
- done  out  1  one-cycle pulse: all jobs retired, or aborted
- err  out  1  sticky timeout flag; cleared when the next `start` is accepted
- dc_done  out  1  one-cycle pulse when the DC job retires; launches the inverse WHT
- q_start  out  1  one-cycle start pulse to the shared quantizer
- q_sel_dc  out  1  1 = engine uses the DC parameter set (q2/iq2/...), 0 = AC set (q1/...)
- q_idx  out  IDX_W  job index muxing the engine input; held stable through the job
- q_done  in  1  quantizer completion pulse
- wr_en  out  1  capture strobe for the engine Rout/levels into slot `wr_idx`
- wr_idx  out  IDX_W  destination slot of `wr_en`
- wr_zero  out  1  qualifies `wr_en`: the slot must be written with all zeros

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; index register = NUM_AC. A reset mid-job returns to IDLE immediately, with no `done` pulse.
- FSM states: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - `start` accepted only in IDLE; `start` in any other state is ignored.
  - On accept: latch `ac_nz`, clear `err`, set idx = NUM_AC, go to ISSUE.
- ISSUE (one cycle):
  - `q_start` = 1; `q_sel_dc` = (idx == NUM_AC); `q_idx` = idx.
  - Go to WAIT; the watchdog clears.
- WAIT:
  - `q_idx` and `q_sel_dc` are held.
  - On `q_done`: `wr_en` = 1 and `wr_idx` = idx in that same cycle, combinationally; `dc_done` = 1 if this was the DC job.
  - Then advance: DC -> idx 0; AC idx k -> k+1; idx NUM_AC-1 -> FIN; otherwise -> ISSUE.
- Job order: DC first, then AC 0..NUM_AC-1.
- Watchdog: counts cycles in WAIT. If it reaches TIMEOUT with no `q_done`, set `err` = 1, emit no `wr_en`, and go to FIN (abort).
- `q_done` on the exact cycle the count reaches TIMEOUT counts as success.
- `q_done` seen in IDLE, ISSUE or FIN is ignored.
- FIN (one cycle): `done` = 1, `busy` drops, go to IDLE. A `start` arriving in FIN is ignored.
- Latency: with the engine answering L cycles after `q_start` (L >= 1), `done` rises 17*(L+1)+1 cycles after the accepted `start`.

Optional Feature:
- Macro: QSCHED_SKIP_ZERO_EN.
- Defined: in ISSUE, an AC job whose latched `ac_nz` bit is 0 issues no `q_start`.
  - Instead, in that same ISSUE cycle: `wr_en` = 1, `wr_zero` = 1, `wr_idx` = idx.
  - The FSM advances directly to the next ISSUE, or to FIN after the last AC job.
  - The DC job is never skipped.
- Undefined: `ac_nz` is ignored and `wr_zero` is tied to 0.

Decomposition:
- Shared package holds:
  - the FSM state enum;
  - the DC_JOB_IDX = NUM_AC constant;
  - the parameter-set select encoding (DC = 1, AC = 0).
- One natural sub-module: `qsched_watchdog`. It is a loadable down-counter of width $clog2(TIMEOUT+1), with clear and enable inputs and an `expired` output.

Test Plan:
- Engine with L = 3, `start` at cycle 0:
  - `q_idx` sequence is 16, 0, 1, ..., 15;
  - `dc_done` fires once, at cycle 4;
  - 17 `wr_en` pulses;
  - `done` fires at cycle 69; `err` = 0.
- Second `start` pulsed while `busy` -> ignored; the job sequence and the `done` time are unchanged.
- Engine withholds `q_done` for AC job 5 -> FIN at TIMEOUT+1 cycles after that `q_start`; `err` = 1; `done` fires once; no `wr_en` for slot 5.
  - The next `start` clears `err`.
- `rst` asserted during WAIT of job 8 -> next cycle all outputs are 0 and the state is IDLE; a later `start` runs the full 17-job sequence.
- QSCHED_SKIP_ZERO_EN, `ac_nz` = 16'h0001, L = 3:
  - engine starts only for jobs 16 and 0;
  - slots 1..15 get `wr_en` with `wr_zero` = 1 on consecutive cycles;
  - `done` fires at cycle 24.
- `q_done` arriving exactly at the TIMEOUT count -> accepted as success; `err` stays 0.

Source files
------------

// File: rtl/quant_sched_pkg.sv
// -----------------------------------------------------------------------------
// quant_sched_pkg
// Shared definitions for the macroblock quantizer scheduler:
//   - default job count / watchdog window / index width
//   - DC_JOB_IDX: the DC job sits just past the last AC job index
//   - parameter-set select encoding driven on q_sel_dc
//   - FSM state encoding (also exported on the scheduler's debug port)
// -----------------------------------------------------------------------------
package quant_sched_pkg;

  localparam int QS_NUM_AC  = 16;
  localparam int QS_TIMEOUT = 64;
  localparam int QS_IDX_W   = 5;

  localparam int DC_JOB_IDX = QS_NUM_AC;

  // q_sel_dc encoding: which quantizer parameter set the engine uses
  localparam logic SEL_DC = 1'b1;
  localparam logic SEL_AC = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/quant_sched_watchdog.sv
// -----------------------------------------------------------------------------
// qsched_watchdog
// Loadable down-counter guarding one quantizer job.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : re-arm to a full window (asserted in the job's issue cycle)
//   en_i       : count one waiting cycle
//   expired_o  : high on the TIMEOUT-th waiting cycle after the re-arm
// The counter is loaded with TIMEOUT-1 so that the first waiting cycle reads
// TIMEOUT-1 and the TIMEOUT-th waiting cycle reads 0.
// -----------------------------------------------------------------------------
module qsched_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/quant_sched.sv
// -----------------------------------------------------------------------------
// quant_sched
// Time-multiplexes one shared quantizer over the 17 jobs of a 16x16 luma
// macroblock: the DC job first, then AC blocks 0..NUM_AC-1.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin sequencing (accepted only when idle)
//   ac_nz           per-AC-block nonzero mask, latched on accepted start
//   busy            high while jobs are being issued / awaited
//   done            one-cycle pulse: all jobs retired, or aborted
//   err             sticky timeout flag, cleared by the next accepted start
//   dc_done         one-cycle pulse when the DC job retires
//   q_start         one-cycle start pulse to the shared quantizer
//   q_sel_dc        parameter set select (SEL_DC / SEL_AC)
//   q_idx           job index, stable through the job
//   q_done          quantizer completion pulse
//   wr_en/wr_idx    capture strobe and destination slot
//   wr_zero         qualifies wr_en: write the slot with all zeros
//   dbg_state       current FSM state (state_t encoding)
//
// Build option QSCHED_SKIP_ZERO_EN: AC jobs whose latched ac_nz bit is 0 are
// not sent to the engine; their slot is zero-filled in the issue cycle.
// Without it ac_nz is ignored and wr_zero is always 0.
//
// Handshake: q_start is a single-cycle request; the engine answers with a
// single-cycle q_done, which is only honoured while waiting. wr_en / wr_idx
// / dc_done are combinational from q_done in that same cycle.
// -----------------------------------------------------------------------------
module quant_sched
  import quant_sched_pkg::*;
#(
  parameter int NUM_AC  = QS_NUM_AC,
  parameter int TIMEOUT = QS_TIMEOUT,
  parameter int IDX_W   = QS_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_AC-1:0] ac_nz,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              dc_done,
  output logic              q_start,
  output logic              q_sel_dc,
  output logic [IDX_W-1:0]  q_idx,
  input  logic              q_done,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic              wr_zero,
  output logic [1:0]        dbg_state
);

  localparam logic [IDX_W-1:0] DC_IDX   = IDX_W'(NUM_AC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_AC - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             wd_clr, wd_en, wd_expired;
  logic             adv;
  logic             is_dc;

`ifdef QSCHED_SKIP_ZERO_EN
  logic [NUM_AC-1:0] nz_q, nz_d;
  logic [NUM_AC-1:0] nz_shr;
  assign nz_shr = nz_q >> idx_q;
`else
  logic unused_nz;
  assign unused_nz = ^ac_nz;
`endif

  assign is_dc = (idx_q == DC_IDX);

  qsched_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= DC_IDX;
      err_q   <= 1'b0;
`ifdef QSCHED_SKIP_ZERO_EN
      nz_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
`ifdef QSCHED_SKIP_ZERO_EN
      nz_q    <= nz_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
`ifdef QSCHED_SKIP_ZERO_EN
    nz_d     = nz_q;
`endif
    busy     = 1'b0;
    done     = 1'b0;
    dc_done  = 1'b0;
    q_start  = 1'b0;
    q_sel_dc = SEL_AC;
    q_idx    = '0;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_zero  = 1'b0;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    adv      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          idx_d   = DC_IDX;
          err_d   = 1'b0;
`ifdef QSCHED_SKIP_ZERO_EN
          nz_d    = ac_nz;
`endif
        end
      end

      ST_ISSUE: begin
        busy     = 1'b1;
        q_idx    = idx_q;
        q_sel_dc = is_dc ? SEL_DC : SEL_AC;
`ifdef QSCHED_SKIP_ZERO_EN
        if (!is_dc && !nz_shr[0]) begin
          // All-zero AC block: zero-fill the slot without using the engine
          wr_en   = 1'b1;
          wr_zero = 1'b1;
          wr_idx  = idx_q;
          adv     = 1'b1;
        end else begin
          q_start = 1'b1;
          wd_clr  = 1'b1;
          state_d = ST_WAIT;
        end
`else
        q_start = 1'b1;
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
`endif
      end

      ST_WAIT: begin
        busy     = 1'b1;
        q_idx    = idx_q;
        q_sel_dc = is_dc ? SEL_DC : SEL_AC;
        wd_en    = 1'b1;
        // q_done wins over expiry so a reply on the last allowed cycle counts
        if (q_done) begin
          wr_en   = 1'b1;
          wr_idx  = idx_q;
          dc_done = is_dc;
          adv     = 1'b1;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Job order: DC, then AC 0 .. NUM_AC-1
    if (adv) begin
      if (is_dc) begin
        idx_d   = '0;
        state_d = ST_ISSUE;
      end else if (idx_q == LAST_IDX) begin
        state_d = ST_FIN;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_ISSUE;
      end
    end
  end

  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
